// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the mem-stage load/store bus sequencer.
// funct3 encodings, FSM state encoding, error cause codes and legality helpers.
// No logic of its own; imported by mem_access_ctrl and mem_lane_fmt.
package mem_access_ctrl_pkg;

  // RISC-V load/store funct3 encodings; funct3[1:0] is the access size.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  // Stores only exist up to SW; loads have holes at 011, 110 and 111.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    if (we) bad = (f3 > F3_SW);
    else    bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    return bad;
  endfunction

  // size is funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      2'b01:   bad = lo[0];
      2'b10:   bad = (lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatter: byte enables, store lane replication, load extract/extend.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: funct3/addr_lo select size and lane; wdata_raw/rdata_raw in, be/wdata/rdata out.
module mem_lane_fmt
  import mem_access_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata_raw,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [31:0] rd_shift;

  always_comb begin
    be    = 4'b1111;
    wdata = wdata_raw;
    case (funct3[1:0])
      F3_SB[1:0]: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{wdata_raw[7:0]}};
      end
      F3_SH[1:0]: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wdata_raw[15:0]}};
      end
      default: ;
    endcase

    // Bring the addressed lane down to bit 0; accesses are aligned so a
    // halfword never straddles the word.
    rd_shift = rdata_raw >> {addr_lo, 3'b000};
    rdata    = rd_shift;
    case (funct3)
      F3_LB:   rdata = {{24{rd_shift[7]}}, rd_shift[7:0]};
      F3_LH:   rdata = {{16{rd_shift[15]}}, rd_shift[15:0]};
      F3_LBU:  rdata = {24'd0, rd_shift[7:0]};
      F3_LHU:  rdata = {16'd0, rd_shift[15:0]};
      F3_LW:   rdata = rd_shift;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Mem-stage load/store sequencer onto a single-outstanding req/ack data bus.
// Latency: bus_req_o one cycle after issue; writeback in the cycle after ack (min 3 cycles).
// Backpressure: stall_o holds the pipeline from issue until the access retires in RESP/ERR.
// Ports: req_* mem-stage request, reg_* writeback, bus_* data bus, err_* one-cycle error pulse.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        reg_we_i,
  input  logic [4:0]  reg_waddr_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stall_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic        err_o,
  output logic [1:0]  err_cause_o
);
  import mem_access_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        cur_f3;
  logic [1:0]        cur_lo;
  logic              cur_load_wb;

  logic [2:0]        fmt_f3;
  logic [1:0]        fmt_lo;
  logic [3:0]        fmt_be;
  logic [31:0]       fmt_wdata;
  logic [31:0]       fmt_rdata;
  logic              req_illegal, req_misalign, timeout_hit;

  // The formatter serves the incoming request while idle (be/wdata are
  // captured at issue) and the captured request afterwards (load extract).
  assign fmt_f3 = (state == ST_IDLE) ? req_funct3_i      : cur_f3;
  assign fmt_lo = (state == ST_IDLE) ? req_addr_i[1:0]   : cur_lo;

  mem_lane_fmt u_fmt (
    .funct3    (fmt_f3),
    .addr_lo   (fmt_lo),
    .wdata_raw (req_wdata_i),
    .rdata_raw (bus_rdata_i),
    .be        (fmt_be),
    .wdata     (fmt_wdata),
    .rdata     (fmt_rdata)
  );

  assign req_illegal  = f3_illegal(req_we_i, req_funct3_i);
  assign req_misalign = misaligned(req_funct3_i[1:0], req_addr_i[1:0]);
  assign timeout_hit  = (TIMEOUT != 0) && (cnt == TO_LAST);

  assign stall_o = ((state == ST_IDLE) && req_valid_i) || (state == ST_BUS);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid_i) state_nxt = (req_illegal || req_misalign) ? ST_ERR : ST_BUS;
      // Ack takes priority over a timeout landing in the same cycle.
      ST_BUS:  if (bus_ack_i)  state_nxt = ST_RESP;
               else if (timeout_hit) state_nxt = ST_ERR;
      ST_RESP: state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cur_f3      <= '0;
      cur_lo      <= '0;
      cur_load_wb <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_be_o    <= '0;
      bus_wdata_o <= '0;
      reg_we_o    <= 1'b0;
      reg_waddr_o <= '0;
      reg_wdata_o <= '0;
      err_o       <= 1'b0;
      err_cause_o <= CAUSE_NONE;
    end else begin
      state       <= state_nxt;
      reg_we_o    <= 1'b0;
      err_o       <= 1'b0;
      err_cause_o <= CAUSE_NONE;
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            if (req_illegal) begin
              err_o       <= 1'b1;
              err_cause_o <= CAUSE_ILLEGAL;
            end else if (req_misalign) begin
              err_o       <= 1'b1;
              err_cause_o <= CAUSE_MISALIGN;
            end else begin
              bus_req_o   <= 1'b1;
              bus_we_o    <= req_we_i;
              bus_addr_o  <= {req_addr_i[31:2], 2'b00};
              bus_be_o    <= fmt_be;
              bus_wdata_o <= fmt_wdata;
              cur_f3      <= req_funct3_i;
              cur_lo      <= req_addr_i[1:0];
              cur_load_wb <= reg_we_i && !req_we_i;
              reg_waddr_o <= reg_waddr_i;
              cnt         <= '0;
            end
          end
        end
        ST_BUS: begin
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            if (cur_load_wb) begin
              reg_we_o    <= 1'b1;
              reg_wdata_o <= fmt_rdata;
            end
          end else if (timeout_hit) begin
            bus_req_o   <= 1'b0;
            err_o       <= 1'b1;
            err_cause_o <= CAUSE_TIMEOUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl with a short timeout so both ack and abort paths are reachable.
// Inputs driven on the falling edge, outputs sampled 1 time unit later.
// Expected values come from a size/offset arithmetic model of RISC-V load/store rules.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_we_i, reg_we_i, bus_ack_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i, req_wdata_i, bus_rdata_i;
  logic [4:0]  reg_waddr_i;
  logic        bus_req_o, bus_we_o, stall_o, reg_we_o, err_o;
  logic [31:0] bus_addr_o, bus_wdata_o, reg_wdata_o;
  logic [3:0]  bus_be_o;
  logic [4:0]  reg_waddr_o;
  logic [1:0]  err_cause_o;

  int n_assert = 0;
  int n_fail   = 0;

  mem_access_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_funct3_i(req_funct3_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
    .stall_o(stall_o), .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o),
    .reg_wdata_o(reg_wdata_o), .err_o(err_o), .err_cause_o(err_cause_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [1:0] model_cause(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    bit legal;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 2'b10;
    if ((addr % acc_size(f3)) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int m;
    m = ((1 << acc_size(f3)) - 1) << (addr % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int sz;
    sz = acc_size(f3);
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v, mask;
    int sz;
    sz = acc_size(f3);
    v = rd >> (8 * (addr % 4));
    if (sz < 4) begin
      mask = (32'd1 << (8 * sz)) - 32'd1;
      v = v & mask;
      if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // One complete access: issue, bus phase (ack after wait_n wait cycles or
  // abort after TO cycles), retire cycle, then two idle cycles with a stray ack.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic rwe, input logic [4:0] waddr,
                        input logic [31:0] rd, input int wait_n);
    logic [1:0] cause;
    bit done;
    cause = model_cause(we, f3, addr);
    done = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3; req_addr_i = addr;
    req_wdata_i = wd; reg_we_i = rwe; reg_waddr_i = waddr; bus_ack_i = 1'b0;
    #1;
    chk1("issue_stall", stall_o, 1'b1);
    chk1("issue_bus_req", bus_req_o, 1'b0);
    if (cause != 2'b00) begin
      @(negedge clk);
      req_valid_i = 1'b0;
      #1;
      chk1("err_pulse", err_o, 1'b1);
      check("err_cause", 32'(err_cause_o), 32'(cause));
      chk1("err_no_req", bus_req_o, 1'b0);
      chk1("err_stall", stall_o, 1'b0);
      chk1("err_no_wb", reg_we_o, 1'b0);
    end else begin
      for (int k = 1; k <= TO; k++) begin
        @(negedge clk);
        if (k == 1) begin
          // Scramble request inputs: the DUT must hold what it captured.
          req_valid_i = 1'b0; req_we_i = 1'($urandom_range(0, 1));
          req_funct3_i = 3'($urandom_range(0, 7)); req_addr_i = $urandom;
          req_wdata_i = $urandom; reg_we_i = 1'($urandom_range(0, 1));
          reg_waddr_i = 5'($urandom_range(0, 31));
        end
        bus_ack_i = (k == wait_n + 1);
        bus_rdata_i = bus_ack_i ? rd : $urandom;
        #1;
        chk1("bus_req", bus_req_o, 1'b1);
        chk1("bus_stall", stall_o, 1'b1);
        chk1("bus_we", bus_we_o, we);
        check("bus_addr", bus_addr_o, addr & 32'hFFFF_FFFC);
        check("bus_be", 32'(bus_be_o), 32'(model_be(f3, addr)));
        if (we) check("bus_wdata", bus_wdata_o, model_wdata(f3, wd));
        chk1("bus_no_wb", reg_we_o, 1'b0);
        chk1("bus_no_err", err_o, 1'b0);
        if (bus_ack_i) begin
          done = 1'b1;
          break;
        end
      end
      @(negedge clk);
      bus_ack_i = 1'b0;
      #1;
      chk1("retire_req_low", bus_req_o, 1'b0);
      chk1("retire_stall", stall_o, 1'b0);
      if (done) begin
        chk1("resp_wb", reg_we_o, !we && rwe);
        chk1("resp_no_err", err_o, 1'b0);
        if (!we && rwe) begin
          check("resp_wdata", reg_wdata_o, model_rdata(f3, addr, rd));
          check("resp_waddr", 32'(reg_waddr_o), 32'(waddr));
        end
      end else begin
        chk1("timeout_err", err_o, 1'b1);
        check("timeout_cause", 32'(err_cause_o), 32'h3);
        chk1("timeout_no_wb", reg_we_o, 1'b0);
      end
    end
    @(negedge clk);
    bus_ack_i = 1'b1;
    #1;
    chk1("idle_wb", reg_we_o, 1'b0);
    chk1("idle_err", err_o, 1'b0);
    chk1("idle_stall", stall_o, 1'b0);
    @(negedge clk);
    bus_ack_i = 1'b0;
    #1;
    chk1("stray_ack_req", bus_req_o, 1'b0);
    chk1("stray_ack_wb", reg_we_o, 1'b0);
    chk1("stray_ack_err", err_o, 1'b0);
  endtask

  initial begin
    rst = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = '0;
    req_addr_i = '0; req_wdata_i = '0; reg_we_i = 1'b0; reg_waddr_i = '0;
    bus_ack_i = 1'b0; bus_rdata_i = '0;
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_bus_req", bus_req_o, 1'b0);
    chk1("rst_stall", stall_o, 1'b0);
    chk1("rst_reg_we", reg_we_o, 1'b0);
    chk1("rst_err", err_o, 1'b0);
    check("rst_cause", 32'(err_cause_o), 32'h0);
    check("rst_bus_be", 32'(bus_be_o), 32'h0);
    rst = 1'b0;

    // Directed cases.
    access(1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 5'd7,  32'h12345678, 3); // LW, 3 waits
    access(1'b0, 3'b000, 32'h103, 32'h0, 1'b1, 5'd8,  32'h80AABBCC, 0); // LB
    access(1'b0, 3'b100, 32'h103, 32'h0, 1'b1, 5'd9,  32'h80AABBCC, 0); // LBU
    access(1'b0, 3'b001, 32'h102, 32'h0, 1'b1, 5'd10, 32'h8001F00D, 1); // LH upper
    access(1'b1, 3'b001, 32'h102, 32'h0000BEEF, 1'b1, 5'd3, 32'h0, 0); // SH
    access(1'b1, 3'b000, 32'h201, 32'h123456A5, 1'b0, 5'd0, 32'h0, 2); // SB
    access(1'b0, 3'b010, 32'h101, 32'h0, 1'b1, 5'd1, 32'h0, 0);        // misaligned LW
    access(1'b0, 3'b011, 32'h100, 32'h0, 1'b1, 5'd1, 32'h0, 0);        // illegal load
    access(1'b1, 3'b100, 32'h100, 32'h0, 1'b0, 5'd1, 32'h0, 0);        // illegal store
    access(1'b0, 3'b010, 32'h104, 32'h0, 1'b1, 5'd2, 32'hCAFEF00D, TO);     // timeout
    access(1'b0, 3'b010, 32'h108, 32'h0, 1'b1, 5'd2, 32'hCAFEF00D, TO - 1); // ack wins
    access(1'b0, 3'b101, 32'h10E, 32'h0, 1'b0, 5'd4, 32'hFFFF1234, 0);  // LHU, no wb

    // Reset while the bus request is outstanding.
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010;
    req_addr_i = 32'h300; reg_we_i = 1'b1; reg_waddr_i = 5'd5;
    @(negedge clk);
    req_valid_i = 1'b0;
    #1;
    chk1("pre_rst_req", bus_req_o, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("midrst_req", bus_req_o, 1'b0);
    chk1("midrst_stall", stall_o, 1'b0);
    chk1("midrst_we", bus_we_o, 1'b0);
    check("midrst_addr", bus_addr_o, 32'h0);
    check("midrst_be", 32'(bus_be_o), 32'h0);
    check("midrst_wdata", bus_wdata_o, 32'h0);
    check("midrst_reg_wdata", reg_wdata_o, 32'h0);
    check("midrst_reg_waddr", 32'(reg_waddr_o), 32'h0);
    chk1("midrst_err", err_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_ack_i = (i == 0);
      #1;
      chk1("post_rst_wb", reg_we_o, 1'b0);
      chk1("post_rst_err", err_o, 1'b0);
    end
    bus_ack_i = 1'b0;
    access(1'b0, 3'b010, 32'h300, 32'h0, 1'b1, 5'd5, 32'h0BADBEEF, 1);

    // Randomized accesses, mostly legal and aligned.
    for (int i = 0; i < 60; i++) begin
      logic we;
      logic [2:0] f3;
      logic [31:0] addr;
      int t;
      we = 1'($urandom_range(0, 1));
      t = $urandom_range(0, 9);
      if (t == 9)       f3 = 3'($urandom_range(0, 7));
      else if (we)      f3 = 3'($urandom_range(0, 2));
      else begin
        t = $urandom_range(0, 4);
        f3 = 3'((t > 2) ? t + 1 : t);
      end
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(acc_size(f3) - 1);
      access(we, f3, addr, $urandom, 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), $urandom, $urandom_range(0, TO + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences load/store instructions leaving the mem stage onto a single-outstanding req/ack data bus.
- Builds byte enables and lane-replicated write data.
- Formats read data (sign/zero extension) for the regs writeback path.
- Holds the pipeline with a stall until the access retires.
- Rejects misaligned or illegal accesses and aborts bus transactions that time out.

Parameters:
TIMEOUT, 255, bus cycles to wait for bus_ack_i before abort; 0 disables timeout
CNT_W, 8, width of timeout counter; must hold TIMEOUT

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_valid_i  in  1  mem-stage instruction is a load or store
req_we_i  in  1  1=store, 0=load
req_funct3_i  in  3  RISC-V funct3 of the load/store
req_addr_i  in  32  byte address
req_wdata_i  in  32  store data (rs2)
reg_we_i  in  1  load writes a register
reg_waddr_i  in  5  destination register
bus_req_o  out  1  bus request, held until ack
bus_we_o  out  1  bus write
bus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
bus_be_o  out  4  byte enables
bus_wdata_o  out  32  lane-replicated write data
bus_ack_i  in  1  bus completes access this cycle
bus_rdata_i  in  32  read data, valid with ack
stall_o  out  1  hold pipeline
reg_we_o  out  1  writeback strobe
reg_waddr_o  out  5  writeback address
reg_wdata_o  out  32  formatted load data
err_o  out  1  one-cycle pulse: misaligned/illegal or timeout
err_cause_o  out  2  01 misaligned, 10 illegal funct3, 11 timeout

Behaviour:
- States: IDLE, BUS, RESP, ERR.
- Reset values: state IDLE; all outputs 0; counter 0.
- stall_o is combinational: 1 when (IDLE && req_valid_i) or BUS; 0 in IDLE without a request, in RESP, and in ERR. The instruction retires in RESP/ERR.
- IDLE with req_valid_i:
  - Legal and aligned: register the request and go to BUS. bus_req_o goes high the next cycle (1-cycle issue latency).
  - Illegal funct3 (load 011/110/111; store >=011) or misaligned (half with addr[0]=1, word with addr[1:0]!=0): go to ERR with no bus activity.
- BUS:
  - Address, be, wdata and we are stable while bus_req_o=1.
  - On bus_ack_i: drop bus_req_o next cycle and go to RESP. For loads with reg_we_i set, load reg_wdata_o and assert reg_we_o.
  - Without ack, the counter increments. When the counter reaches TIMEOUT-1 without ack (TIMEOUT!=0): drop bus_req_o and go to ERR with cause 11.
  - Ack on the timeout cycle wins: the access completes normally.
- RESP: reg_we_o is high for exactly one cycle (loads only; 0 for stores and for reg_we_i=0). Then IDLE.
  - Minimum load-to-writeback is 3 cycles with zero-wait ack (issue, BUS, RESP).
  - A new req_valid_i is not sampled in RESP; it is sampled in the following IDLE cycle.
- ERR: err_o and err_cause_o valid for exactly one cycle, no writeback, then IDLE.
- Byte enables:
  - SB/LB/LBU: 1<<addr[1:0].
  - SH/LH/LHU: addr[1]?1100:0011.
  - SW/LW: 1111. Loads drive be as well.
- Write data: SB replicates the byte to all 4 lanes; SH replicates the half to both halves; SW passes through.
- Read format: select the lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Ack while not in BUS is ignored.
- Reset mid-access: bus_req_o drops at the reset edge; no writeback or err pulse; the pending access is lost.

Decomposition:
- Shared package holds:
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - State encoding.
  - err_cause codes.
- One sub-module: mem_lane_fmt. It is purely combinational: be/wdata generation plus read extraction and extension from funct3 and addr[1:0]. The FSM, counter and registers stay in mem_access_ctrl.

Test Plan:
- LW addr 0x100, bus_rdata 0x12345678, ack after 3 wait cycles -> bus_be 1111, bus_addr 0x100, stall high 5 cycles, reg_we_o 1 cycle with reg_wdata 0x12345678.
- LB addr 0x103, rdata 0x80AABBCC -> be 1000, reg_wdata 0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr 0x102, wdata 0x0000BEEF, zero-wait ack -> bus_we 1, be 1100, bus_wdata 0xBEEFBEEF, reg_we_o stays 0.
- LW addr 0x101 -> no bus_req_o ever, err_o 1 cycle with cause 01. funct3 011 load -> err cause 10.
- TIMEOUT=4, never ack -> bus_req high 4 cycles then drops, err cause 11. Ack on the 4th cycle -> normal RESP with no err.
- rst asserted while in BUS -> next cycle all outputs 0, state IDLE, no reg_we_o/err_o afterward. A new LW then completes normally.
